// File: rtl/snes_controller_responder_if.sv
// Host-facing signal bundle for the SNES controller responder: latch/shift clock
// and buttons in, serial frame data and status out.
interface snes_controller_responder_if #(
  parameter int NUM_BUTTONS = 12,
  parameter int FRAME_BITS  = 16
);
  localparam int CNT_W = $clog2(FRAME_BITS) + 1;

  logic                   data_latch;
  logic                   snes_clk;
  logic [NUM_BUTTONS-1:0] buttons;
  logic                   serial_data;
  logic                   busy;
  logic                   frame_done;
  logic [CNT_W-1:0]       bit_count;

  modport master (
    output data_latch, snes_clk, buttons,
    input  serial_data, busy, frame_done, bit_count
  );

  modport slave (
    input  data_latch, snes_clk, buttons,
    output serial_data, busy, frame_done, bit_count
  );
endinterface

// File: rtl/snes_controller_responder.sv
// Device side of the SNES pad protocol: latches buttons, shifts a 16-bit active-low frame.
// Define SNES_RESP_SYNC_EN for 2-flop input synchronizers (truly asynchronous hosts).
module snes_controller_responder #(
  parameter int   NUM_BUTTONS = 12,
  parameter int   FRAME_BITS  = 16,
  parameter logic TAIL_LEVEL  = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  snes_controller_responder_if.slave   bus
);
  localparam int CNT_W = $clog2(FRAME_BITS) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  logic w_s_latch;
  logic w_s_clk;

`ifdef SNES_RESP_SYNC_EN
  logic r_latch_m, r_latch_s, r_clk_m, r_clk_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch_m <= 1'b0;
      r_latch_s <= 1'b0;
      r_clk_m   <= 1'b1;
      r_clk_s   <= 1'b1;
    end else begin
      r_latch_m <= bus.data_latch;
      r_latch_s <= r_latch_m;
      r_clk_m   <= bus.snes_clk;
      r_clk_s   <= r_clk_m;
    end
  end

  assign w_s_latch = r_latch_s;
  assign w_s_clk   = r_clk_s;
`else
  logic r_latch_s, r_clk_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch_s <= 1'b0;
      r_clk_s   <= 1'b1;
    end else begin
      r_latch_s <= bus.data_latch;
      r_clk_s   <= bus.snes_clk;
    end
  end

  assign w_s_latch = r_latch_s;
  assign w_s_clk   = r_clk_s;
`endif

  logic r_latch_prev, r_clk_prev;
  logic w_latch_rise, w_latch_fall, w_clk_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch_prev <= 1'b0;
      r_clk_prev   <= 1'b1;
    end else begin
      r_latch_prev <= w_s_latch;
      r_clk_prev   <= w_s_clk;
    end
  end

  assign w_latch_rise = w_s_latch & ~r_latch_prev;
  assign w_latch_fall = ~w_s_latch & r_latch_prev;
  assign w_clk_rise   = w_s_clk & ~r_clk_prev;

  // Frame image: inverted buttons in the low bits, padding reads as "not pressed".
  logic [FRAME_BITS-1:0] w_frame;

  always_comb begin
    w_frame                  = {FRAME_BITS{1'b1}};
    w_frame[NUM_BUTTONS-1:0] = ~bus.buttons;
  end

  state_t                r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_sh, w_sh_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_done_evt, w_done_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sh       <= {FRAME_BITS{1'b1}};
      r_cnt      <= '0;
      r_done_evt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sh       <= w_sh_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done_evt <= w_done_evt;
    end
  end

  // A new latch always restarts the frame, even mid-shift and even on a coincident clk edge.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_done_evt  = 1'b0;
    if (w_latch_rise) begin
      w_state_nxt = LOAD;
      w_sh_nxt    = w_frame;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        LOAD: begin
          w_cnt_nxt = '0;
          if (w_s_latch) begin
            w_sh_nxt = w_frame;
          end
          if (w_latch_fall) begin
            w_state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (w_clk_rise && !w_s_latch) begin
            w_sh_nxt = {1'b1, r_sh[FRAME_BITS-1:1]};
            if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
              w_state_nxt = DONE;
              w_cnt_nxt   = CNT_W'(FRAME_BITS);
              w_done_evt  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output register stage: every output is a registered view of the FSM state.
  logic             r_serial_data, r_busy, r_frame_done;
  logic [CNT_W-1:0] r_bit_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_serial_data <= 1'b1;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_bit_count   <= '0;
    end else begin
      case (r_state)
        LOAD, SHIFT: r_serial_data <= r_sh[0];
        DONE:        r_serial_data <= TAIL_LEVEL;
        default:     r_serial_data <= 1'b1;
      endcase
      r_busy       <= (r_state == SHIFT);
      r_frame_done <= r_done_evt;
      r_bit_count  <= r_cnt;
    end
  end

  assign bus.serial_data = r_serial_data;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_frame_done;
  assign bus.bit_count   = r_bit_count;
endmodule
